bus_router: RTL

- Single-outstanding-transaction router between the core's memory-request port and the device bus.
- Decodes each 16-bit address into a device ID (did_t: DRAM..DSPI, DNON = unmapped) using the fixed memory map below.
- Forwards the request to the device bus with a valid/ready handshake and waits for the device response.
- Returns read data or an error to the requester; a programmable watchdog aborts hung devices.

---
 rtl/bus_router.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bus_router.sv
// bus_router: single-outstanding router from the core request port
// to the device bus, with address decode and a response watchdog.
package params_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 256;

  typedef enum logic [2:0] {
    DRAM, DROM, DMAT, DINT,
    DREG, DEXE, DSPI, DNON
  } did_t;
endpackage

module bus_router #(
  parameter int ADDR_W   = params_pkg::ADDR_W,
  parameter int DATA_W   = params_pkg::DATA_W,
  parameter int TIMEOUT  = 64,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_req_valid,
  output logic                m_req_ready,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic                m_we,
  input  logic [DATA_W-1:0]   m_wdata,
  output logic                m_rsp_valid,
  input  logic                m_rsp_ready,
  output logic [DATA_W-1:0]   m_rsp_rdata,
  output logic                m_rsp_err,
  output logic                d_req_valid,
  input  logic                d_req_ready,
  output params_pkg::did_t    d_did,
  output logic [ADDR_W-1:0]   d_addr,
  output logic                d_we,
  output logic [DATA_W-1:0]   d_wdata,
  input  logic                d_rsp_valid,
  input  logic [DATA_W-1:0]   d_rsp_rdata,
  output logic [ERRCNT_W-1:0] err_count
);
  import params_pkg::*;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } st_t;

  st_t st;
  logic [TW-1:0] tmr;
  logic expire;
  did_t dec_did;
  logic [ADDR_W-1:0] dec_off;

  assign expire = (tmr == TLAST);

  always_comb begin
    dec_did = DNON;
    dec_off = '0;
    unique case (1'b1)
      (m_addr[15] == 1'b0): begin
        dec_did = DRAM;
        dec_off = m_addr & ADDR_W'(16'h7FFF);
      end
      (m_addr[15:13] == 3'b100): begin
        dec_did = DROM;
        dec_off = m_addr & ADDR_W'(16'h1FFF);
      end
      (m_addr[15:12] == 4'hA): begin
        dec_did = DMAT;
        dec_off = m_addr & ADDR_W'(16'h0FFF);
      end
      (m_addr[15:8] == 8'hB0): begin
        dec_did = DINT;
        dec_off = m_addr & ADDR_W'(16'h00FF);
      end
      (m_addr[15:8] == 8'hB1): begin
        dec_did = DREG;
        dec_off = m_addr & ADDR_W'(16'h00FF);
      end
      (m_addr[15:8] == 8'hB2): begin
        dec_did = DEXE;
        dec_off = m_addr & ADDR_W'(16'h00FF);
      end
      (m_addr[15:8] == 8'hB3): begin
        dec_did = DSPI;
        dec_off = m_addr & ADDR_W'(16'h00FF);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      tmr         <= '0;
      m_req_ready <= 1'b1;
      m_rsp_valid <= 1'b0;
      m_rsp_err   <= 1'b0;
      m_rsp_rdata <= '0;
      d_req_valid <= 1'b0;
      d_did       <= DNON;
      d_addr      <= '0;
      d_we        <= 1'b0;
      d_wdata     <= '0;
      err_count   <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (m_req_valid) begin
            m_req_ready <= 1'b0;
            if (dec_did == DNON) begin
              st          <= RESP;
              m_rsp_valid <= 1'b1;
              m_rsp_err   <= 1'b1;
              m_rsp_rdata <= '0;
            end else begin
              st          <= ISSUE;
              tmr         <= '0;
              d_req_valid <= 1'b1;
              d_did       <= dec_did;
              d_addr      <= dec_off;
              d_we        <= m_we;
              d_wdata     <= m_wdata;
            end
          end
        end
        ISSUE: begin
          if (expire) begin
            st          <= RESP;
            d_req_valid <= 1'b0;
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b1;
            m_rsp_rdata <= '0;
          end else begin
            tmr <= tmr + 1'b1;
            if (d_req_ready) begin
              st          <= WAIT;
              d_req_valid <= 1'b0;
            end
          end
        end
        WAIT: begin
          // a response on the expiry cycle beats the watchdog
          if (d_rsp_valid) begin
            st          <= RESP;
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b0;
            m_rsp_rdata <= d_we ? '0 : d_rsp_rdata;
          end else if (expire) begin
            st          <= RESP;
            m_rsp_valid <= 1'b1;
            m_rsp_err   <= 1'b1;
            m_rsp_rdata <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RESP: begin
          if (m_rsp_ready) begin
            st          <= IDLE;
            m_rsp_valid <= 1'b0;
            m_req_ready <= 1'b1;
            m_rsp_err   <= 1'b0;
            m_rsp_rdata <= '0;
            if (m_rsp_err && !(&err_count))
              err_count <= err_count + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
